seq_mult8x8: RTL and testbench

SEQ_MULT8X8 -- requirements
Module: seq_mult8x8

---
 rtl/seq_mult8x8.sv | 128 ++++++++++++
 tb/tb_seq_mult8x8.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult8x8.sv
// Sequential 8x8 unsigned multiplier: accumulates four shifted 4x4 partial products
// over four cycles and shows the controller state on an active-low seven-segment display.
module seq_mult8x8 (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product8x8,
  output logic        done_flag,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LSB  = 3'd1,
    MID  = 3'd2,
    MSB  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  opa_q, opa_d;
  logic [7:0]  opb_q, opb_d;
  logic        done_q, done_d;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic [6:0]  seg;

  // Bit 6 drives segment a, bit 0 drives segment g; a 0 lights the segment.
  function automatic logic [6:0] seg_decode(input logic [2:0] code);
    logic [6:0] pattern;
    case (code)
      3'd0:    pattern = 7'b0000001;
      3'd1:    pattern = 7'b1001111;
      3'd2:    pattern = 7'b0010010;
      3'd3:    pattern = 7'b0000110;
      3'd4:    pattern = 7'b1001100;
      default: pattern = 7'b1111111;
    endcase
    return pattern;
  endfunction

  always_comb begin
    // count[1] picks the high nibble of A, count[0] the high nibble of B
    nib_a = count_q[1] ? opa_q[7:4] : opa_q[3:0];
    nib_b = count_q[0] ? opb_q[7:4] : opb_q[3:0];
    pp    = {4'b0000, nib_a} * {4'b0000, nib_b};
    case (count_q)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd3:    pp_shifted = {pp, 8'h00};
      default: pp_shifted = {4'h0, pp, 4'h0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LSB;
          count_d = 2'd0;
          acc_d   = 16'h0000;
          opa_d   = dataa;
          opb_d   = datab;
        end
      end
      LSB: begin
        acc_d   = acc_q + pp_shifted;
        count_d = 2'd1;
        state_d = MID;
      end
      MID: begin
        acc_d = acc_q + pp_shifted;
        if (count_q == 2'd1) begin
          count_d = 2'd2;
        end else begin
          count_d = 2'd3;
          state_d = MSB;
        end
      end
      MSB: begin
        acc_d   = acc_q + pp_shifted;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      acc_q   <= 16'h0000;
      opa_q   <= 8'h00;
      opb_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      done_q  <= done_d;
    end
  end

  assign seg                 = seg_decode(state_q);
  assign {a, b, c, d, e, f, g} = seg;
  assign product8x8          = acc_q;
  assign done_flag           = done_q;

endmodule

// File: tb/tb_seq_mult8x8.sv
// Bench for seq_mult8x8: directed operations checked every cycle against an
// arithmetic model, plus literal expectations for the documented scenarios.
module tb_seq_mult8x8;

  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dataa = 8'h00;
  logic [7:0]  datab = 8'h00;
  logic [15:0] product8x8;
  logic        done_flag;
  logic        a, b, c, d, e, f, g;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult8x8 dut (
    .clk(clk), .reset_a(reset_a), .start(start), .dataa(dataa), .datab(datab),
    .product8x8(product8x8), .done_flag(done_flag),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  logic [6:0] seg_tab [0:4];
  initial begin
    seg_tab[0] = 7'b0000001;
    seg_tab[1] = 7'b1001111;
    seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110;
    seg_tab[4] = 7'b1001100;
  end

  // Model: m_n = -1 when idle, 0..4 = edges elapsed since start was accepted.
  int         m_n = -1;
  logic       m_valid = 1'b0;
  int         m_a = 0;
  int         m_b = 0;

  function automatic int psum(input int x, input int y, input int n);
    int s;
    s = 0;
    if (n >= 1) s += (x % 16) * (y % 16);
    if (n >= 2) s += (x % 16) * (y / 16) * 16;
    if (n >= 3) s += (x / 16) * (y % 16) * 16;
    if (n >= 4) s += (x / 16) * (y / 16) * 256;
    return s;
  endfunction

  function automatic int code_of(input int n);
    if (n < 0)  return 0;
    if (n == 0) return 1;
    if (n <= 2) return 2;
    if (n == 3) return 3;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset_a) begin
      m_n     = -1;
      m_valid = 1'b1;
      m_a     = 0;
      m_b     = 0;
    end else if (m_valid) begin
      if ((m_n < 0 || m_n == 4) && start) begin
        m_a = int'(dataa);
        m_b = int'(datab);
        m_n = 0;
      end else if (m_n >= 0 && m_n < 4) begin
        m_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_product", product8x8, 16'(psum(m_a, m_b, m_n)));
      chk("model_done", {15'b0, done_flag}, {15'b0, (m_n == 4)});
      chk("model_segments", {9'b0, a, b, c, d, e, f, g}, {9'b0, seg_tab[code_of(m_n)]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [7:0] x, input logic [7:0] y);
    dataa = x;
    datab = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [15:0] sums [0:3];

  initial begin
    sums[0] = 16'd225;
    sums[1] = 16'd3825;
    sums[2] = 16'd7425;
    sums[3] = 16'd65025;

    reset_a = 1'b1;
    tick();
    tick();
    chk("reset_product", product8x8, 16'd0);
    chk("reset_done", {15'b0, done_flag}, 16'd0);
    chk("reset_segments", {9'b0, a, b, c, d, e, f, g}, 16'b0000001);
    reset_a = 1'b0;
    tick();

    go(8'd12, 8'd4);
    chk("t12x4_seg_lsb", {9'b0, a, b, c, d, e, f, g}, 16'b1001111);
    chk("t12x4_cleared", product8x8, 16'd0);
    tick();
    chk("t12x4_seg_mid1", {9'b0, a, b, c, d, e, f, g}, 16'b0010010);
    tick();
    chk("t12x4_seg_mid2", {9'b0, a, b, c, d, e, f, g}, 16'b0010010);
    chk("t12x4_done_low", {15'b0, done_flag}, 16'd0);
    tick();
    chk("t12x4_seg_msb", {9'b0, a, b, c, d, e, f, g}, 16'b0000110);
    tick();
    chk("t12x4_seg_done", {9'b0, a, b, c, d, e, f, g}, 16'b1001100);
    chk("t12x4_product", product8x8, 16'd48);
    chk("t12x4_done", {15'b0, done_flag}, 16'd1);
    tick();

    go(8'd255, 8'd255);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t255_partial", product8x8, sums[i]);
    end
    chk("t255_done", {15'b0, done_flag}, 16'd1);

    dataa = 8'h5A;
    datab = 8'hC3;
    start = 1'b1;
    tick();
    tick();
    dataa = 8'hFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("long_start_product", product8x8, 16'd17550);
    chk("long_start_done", {15'b0, done_flag}, 16'd1);
    tick();

    go(8'd7, 8'd9);
    chk("restart_cleared", product8x8, 16'd0);
    chk("restart_done_low0", {15'b0, done_flag}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("restart_done_low", {15'b0, done_flag}, 16'd0);
    end
    tick();
    chk("restart_done", {15'b0, done_flag}, 16'd1);
    chk("restart_product", product8x8, 16'd63);

    go(8'd3, 8'd3);
    tick();
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    chk("midreset_product", product8x8, 16'd0);
    chk("midreset_done", {15'b0, done_flag}, 16'd0);
    chk("midreset_segments", {9'b0, a, b, c, d, e, f, g}, 16'b0000001);
    tick();
    chk("idle_hold_segments", {9'b0, a, b, c, d, e, f, g}, 16'b0000001);

    go(8'd0, 8'd200);
    repeat (4) tick();
    chk("zero_product", product8x8, 16'd0);
    chk("zero_done", {15'b0, done_flag}, 16'd1);

    go(8'd1, 8'd1);
    repeat (4) tick();
    chk("one_product", product8x8, 16'd1);
    chk("one_done", {15'b0, done_flag}, 16'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
